up_sample2x: RTL
================

Name: up_sample2x

Overview:
- 2x2 nearest-neighbour up-sampler (un-pool) for the pooled feature-map stream.
- Each accepted input pixel vector (DN lanes x DW bits) is emitted twice horizontally. Each completed input row is then replayed once from an internal line buffer, giving 2x vertical replication.
- Sits on the decoder/expansion path, the opposite direction to the 2x2 max-pool stage.
- Valid/ready on both sides. Registered output stage. Bypass mode passes data through unchanged.

Parameters:
- DW, 8, bits per lane
- DN, 6, lanes per beat
- BUF_DEPTH, 64, line-buffer entries; max pooled row width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- m_data  input  DN*DW  input pixel vector
- m_valid  input  1  input beat valid
- m_ready  output  1  input beat accepted when m_valid && m_ready
- m_width  input  6  input row width in beats; 0 encodes 64
- m_up_en  input  1  1 = up-sample, 0 = pass-through
- s_data  output  DN*DW  output pixel vector (registered)
- s_valid  output  1  output beat valid (registered)
- s_ready  input  1  downstream ready

Behaviour:
- Reset values: s_valid=0, s_data=0, m_ready=0 during reset. State=IDLE_ROW0, idx=0, phase=0. Latched width/mode cleared to 64/bypass. Line-buffer contents are not reset (don't-care).
- Output register update:
  - load = !s_valid || s_ready.
  - When load and no new beat is produced: s_valid <= 0.
  - s_data holds while s_valid && !s_ready.
- Configuration latch: m_width and m_up_en are sampled only on the first accepted beat of a row pair (state ROW0, idx=0, phase=0). Changes at any other time are ignored until the next row-pair start. Latched width value 0 means 64.
- Bypass (latched mode=0):
  - m_ready = load.
  - An accepted beat appears on s_data/s_valid the next cycle (latency 1).
  - One output per cycle at full throughput.
  - The row counter still runs so that re-sampling happens at the row boundary.
- Up-sample state machine, with counters idx (0..W-1) and phase (0/1):
  - ROW0, phase 0:
    - m_ready = load.
    - On accept: s_data <= m_data, s_valid <= 1; buf[idx] <= m_data; hold <= m_data; phase -> 1.
  - ROW0, phase 1:
    - m_ready = 0.
    - On load: s_data <= hold, s_valid <= 1, phase -> 0.
    - If idx==W-1: idx -> 0, state -> ROW1. Else idx+1.
  - ROW1:
    - m_ready = 0.
    - Read buf[idx]. On load: emit it at phase 0, then again at phase 1.
    - After phase 1 of idx==W-1: idx -> 0, state -> ROW0.
- Line-buffer read: synchronous read with prefetch, so ROW1 sustains one output per cycle with no bubble at the ROW0->ROW1 transition or between entries.
- Throughput:
  - Up-sample mode: 4*W output beats per W input beats.
  - Input is accepted at most every other cycle during ROW0, never during ROW1.
- Backpressure: s_ready low freezes state, idx, phase and s_data. No beat is lost or duplicated beyond the 2x rule.
- Simultaneous events: when s_valid && s_ready in the same cycle as a new production, the new beat replaces the old one (no bubble).
- Reset mid-row: synchronous reset at any point aborts the row pair. The next accepted beat starts a fresh ROW0 with re-sampled config. Partial rows are discarded.
- Width arithmetic: idx is a 6-bit counter; wrap compare is against (W-1) using a 7-bit latched width (1..64).

Decomposition:
- Shared package up_pkg:
  - default DW/DN
  - state encoding (ST_ROW0, ST_ROW1)
  - BUF_DEPTH constant
  - width-decode helper (0 -> 64)
- One sub-module, up_line_buf: BUF_DEPTH x (DN*DW) simple dual-port RAM, one write port and one synchronous read port. Inferable as BRAM/LUTRAM.
- The FSM, counters and output register stay in up_sample2x.

Test Plan:
- Basic up-sample: up_en=1, width=3, inputs A,B,C, s_ready=1 -> s_data sequence A,A,B,B,C,C,A,A,B,B,C,C. First output 1 cycle after accepting A. 12 consecutive s_valid beats. m_ready low during all of ROW1.
- Backpressure: same stimulus, s_ready toggled 1,0,0,1,... in a random pattern -> identical 12-beat sequence. s_data stable whenever s_valid && !s_ready.
- Bypass: up_en=0, width=4, inputs 0x01..0x04 in lane 0 -> outputs 0x01..0x04 with 1-cycle latency. m_ready tracks load. No replication.
- Max width: width=0, 64 beats with lane 0 = index 0..63 -> 256 outputs: indices 0,0,1,1,...,63,63 twice. No ROW0->ROW1 bubble with s_ready=1.
- Mid-pair config change: width switched 3->5 during ROW1 -> current pair completes at width 3. Next pair uses width 5 (20 outputs).
- Reset mid-operation: rst asserted for 1 cycle after 2 ROW0 beats -> s_valid=0 next cycle. A subsequent width=2 pair X,Y -> X,X,Y,Y,X,X,Y,Y with no stale data.

Source files
------------

// File: rtl/up_pkg.sv
// Shared types and constants for the 2x2 nearest-neighbour up-sampler.
package up_pkg;

  localparam int UP_DW        = 8;
  localparam int UP_DN        = 6;
  localparam int UP_BUF_DEPTH = 64;
  localparam int UP_IDX_W     = 6;

  typedef enum logic {
    ST_ROW0 = 1'b0,
    ST_ROW1 = 1'b1
  } up_state_e;

  // A width code of 0 stands for a full 64-beat row.
  function automatic logic [UP_IDX_W:0] decode_width(input logic [UP_IDX_W-1:0] w);
    return (w == '0) ? 7'd64 : {1'b0, w};
  endfunction

endpackage

// File: rtl/up_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module up_line_buf #(
  parameter int VW    = 48,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [VW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [VW-1:0] o_rd_data
);

  logic [VW-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it can map onto block/distributed RAM;
  // every entry is written in ROW0 before ROW1 reads it.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/up_sample2x.sv
// 2x2 nearest-neighbour up-sampler: each beat is emitted twice, each row replayed
// once from the line buffer. Bypass mode forwards beats with one cycle of latency.
module up_sample2x
  import up_pkg::*;
#(
  parameter int DW        = UP_DW,
  parameter int DN        = UP_DN,
  parameter int BUF_DEPTH = UP_BUF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DN*DW-1:0]    m_data,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [UP_IDX_W-1:0] m_width,
  input  logic                m_up_en,
  output logic [DN*DW-1:0]    s_data,
  output logic                s_valid,
  input  logic                s_ready
);

  localparam int VW = DN * DW;

  up_state_e             r_state,   w_state_nxt;
  logic [UP_IDX_W-1:0]   r_idx,     w_idx_nxt;
  logic                  r_phase,   w_phase_nxt;
  logic                  r_up_en,   w_up_en_nxt;
  logic [UP_IDX_W:0]     r_width,   w_width_nxt;
  logic [VW-1:0]         r_hold,    w_hold_nxt;
  logic [VW-1:0]         r_s_data,  w_s_data_nxt;
  logic                  r_s_valid, w_s_valid_nxt;

  logic                  w_load, w_row_start, w_up_en, w_last, w_accept, w_wr_en;
  logic [UP_IDX_W:0]     w_width;
  logic [UP_IDX_W-1:0]   w_idx_inc;
  logic [VW-1:0]         w_rd_data;

  assign w_load      = !r_s_valid || s_ready;
  assign w_row_start = (r_state == ST_ROW0) && (r_idx == '0) && !r_phase;

  // Config is taken live from the ports on the first beat of a row pair.
  assign w_up_en   = w_row_start ? m_up_en : r_up_en;
  assign w_width   = w_row_start ? decode_width(m_width) : r_width;
  assign w_last    = ({1'b0, r_idx} == (w_width - 7'd1));
  assign w_idx_inc = w_last ? '0 : r_idx + 6'd1;

  assign m_ready  = !rst && w_load && (r_state == ST_ROW0) && !r_phase;
  assign w_accept = m_valid && m_ready;

  assign s_data  = r_s_data;
  assign s_valid = r_s_valid;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_phase_nxt   = r_phase;
    w_up_en_nxt   = r_up_en;
    w_width_nxt   = r_width;
    w_hold_nxt    = r_hold;
    w_s_data_nxt  = r_s_data;
    w_s_valid_nxt = r_s_valid;
    w_wr_en       = 1'b0;

    if (w_load) begin
      w_s_valid_nxt = 1'b0;
      unique case (r_state)
        ST_ROW0: begin
          if (!r_phase) begin
            if (w_accept) begin
              w_s_data_nxt  = m_data;
              w_s_valid_nxt = 1'b1;
              if (w_row_start) begin
                w_up_en_nxt = m_up_en;
                w_width_nxt = decode_width(m_width);
              end
              if (w_up_en) begin
                w_wr_en     = 1'b1;
                w_hold_nxt  = m_data;
                w_phase_nxt = 1'b1;
              end else begin
                w_idx_nxt = w_idx_inc;
              end
            end
          end else begin
            w_s_data_nxt  = r_hold;
            w_s_valid_nxt = 1'b1;
            w_phase_nxt   = 1'b0;
            w_idx_nxt     = w_idx_inc;
            if (w_last) w_state_nxt = ST_ROW1;
          end
        end
        ST_ROW1: begin
          w_s_data_nxt  = w_rd_data;
          w_s_valid_nxt = 1'b1;
          w_phase_nxt   = !r_phase;
          if (r_phase) begin
            w_idx_nxt = w_idx_inc;
            if (w_last) w_state_nxt = ST_ROW0;
          end
        end
        default: w_state_nxt = ST_ROW0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ROW0;
      r_idx     <= '0;
      r_phase   <= 1'b0;
      r_up_en   <= 1'b0;
      r_width   <= 7'd64;
      r_hold    <= '0;
      r_s_data  <= '0;
      r_s_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_phase   <= w_phase_nxt;
      r_up_en   <= w_up_en_nxt;
      r_width   <= w_width_nxt;
      r_hold    <= w_hold_nxt;
      r_s_data  <= w_s_data_nxt;
      r_s_valid <= w_s_valid_nxt;
    end
  end

  // Reading at the next index prefetches the entry ROW1 emits on the following load.
  up_line_buf #(
    .VW   (VW),
    .DEPTH(BUF_DEPTH),
    .AW   (UP_IDX_W)
  ) u_line_buf (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_idx),
    .i_wr_data(m_data),
    .i_rd_addr(w_idx_nxt),
    .o_rd_data(w_rd_data)
  );

endmodule
